// File: rtl/alu_wide_seq_pkg.sv
// rtl/alu_wide_seq_pkg.sv - shared state encoding, flag indices and flag-combine helper
package alu_wide_seq_pkg;

  // Sequencer states: idle, low-byte pass, high-byte pass, response held
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit positions inside every 4-bit flag vector (ALU and response)
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_SIGN     = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_W        = 4;

  // Request fields captured on acceptance
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        invert;
    logic        carry_in;
    logic        wide;
  } req_t;

  // Final flags of a 16-bit op: carry/sign/overflow come from the high pass,
  // zero is either chained across both passes or taken from the high pass alone
  function automatic logic [FLAG_W-1:0] wide_flags(
    input logic [FLAG_W-1:0] lo_flags,
    input logic [FLAG_W-1:0] hi_flags,
    input logic              chain_zero
  );
    logic [FLAG_W-1:0] f;
    f = hi_flags;
    if (chain_zero) begin
      f[FLAG_ZERO] = lo_flags[FLAG_ZERO] & hi_flags[FLAG_ZERO];
    end else begin
      f[FLAG_ZERO] = hi_flags[FLAG_ZERO];
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// rtl/alu_wide_seq.sv - sequences 8/16-bit ops through an external 8-bit ALU
module alu_wide_seq
  import alu_wide_seq_pkg::*;
#(
  parameter bit CHAIN_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  input  logic        req_invert,
  input  logic        req_carry_in,
  input  logic        req_wide,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_invert,
  output logic        alu_carry_in,
  output logic        alu_n_oe,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags
);

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  req_t               req_q;
  logic [15:0]        result_q;
  logic [FLAG_W-1:0]  lo_flags_q;
  logic [FLAG_W-1:0]  flags_q;

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

  // State register; reset drops straight back to idle, abandoning any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake and ALU drive; ALU is only enabled during the two passes
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_op       = 4'h0;
    alu_invert   = 1'b0;
    alu_carry_in = 1'b0;
    alu_n_oe     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // rst_n gating keeps ready low while reset is still asserted
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          accept  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        alu_a        = req_q.a[7:0];
        alu_b        = req_q.b[7:0];
        alu_op       = req_q.op;
        alu_invert   = req_q.invert;
        alu_carry_in = req_q.carry_in;
        alu_n_oe     = 1'b0;
        state_d      = req_q.wide ? ST_HI : ST_DONE;
      end
      ST_HI: begin
        alu_a        = req_q.a[15:8];
        alu_b        = req_q.b[15:8];
        alu_op       = req_q.op;
        alu_invert   = req_q.invert;
        alu_carry_in = lo_flags_q[FLAG_CARRY];
        alu_n_oe     = 1'b0;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // Response leaving frees the sequencer for a same-cycle request
          req_ready = 1'b1;
          if (req_valid) begin
            accept  = 1'b1;
            state_d = ST_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture and per-pass result/flag accumulation; result is untouched in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      result_q   <= 16'h0000;
      lo_flags_q <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        req_q.a        <= req_a;
        req_q.b        <= req_b;
        req_q.op       <= req_op;
        req_q.invert   <= req_invert;
        req_q.carry_in <= req_carry_in;
        req_q.wide     <= req_wide;
      end
      case (state_q)
        ST_LO: begin
          result_q[7:0] <= alu_result;
          lo_flags_q    <= alu_flags;
          if (!req_q.wide) begin
            result_q[15:8] <= 8'h00;
            flags_q        <= alu_flags;
          end
        end
        ST_HI: begin
          result_q[15:8] <= alu_result;
          flags_q        <= wide_flags(lo_flags_q, alu_flags, CHAIN_ZERO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb/tb_alu_wide_seq.sv - directed bench for alu_wide_seq with both CHAIN_ZERO settings
module tb_alu_wide_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_op;
  logic        req_invert, req_carry_in, req_wide;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, alu_invert1, alu_carry_in1, alu_n_oe1;
  logic [15:0] rsp_result1;
  logic [3:0]  rsp_flags1, alu_op1, alu_flags1;
  logic [7:0]  alu_a1, alu_b1, alu_result1;

  logic        req_ready0, rsp_valid0, alu_invert0, alu_carry_in0, alu_n_oe0;
  logic [15:0] rsp_result0;
  logic [3:0]  rsp_flags0, alu_op0, alu_flags0;
  logic [7:0]  alu_a0, alu_b0, alu_result0;

  int total = 0;
  int bad   = 0;

  // 8-bit ALU: op0 add, op1 and, op2 or, op3 xor, else pass a; returns {V,S,C,Z,result}
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op, input logic inv,
                                            input logic cin);
    logic [7:0] bb;
    logic [8:0] sum;
    logic [7:0] r;
    logic       c, v;
    bb  = inv ? ~b : b;
    sum = 9'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      4'd0: begin
        sum = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
        r   = sum[7:0];
        c   = sum[8];
        v   = (a[7] == bb[7]) && (r[7] != a[7]);
      end
      4'd1:    r = a & bb;
      4'd2:    r = a | bb;
      4'd3:    r = a ^ bb;
      default: r = a;
    endcase
    return {v, r[7], c, (r == 8'd0), r};
  endfunction

  always_comb {alu_flags1, alu_result1} = alu_model(alu_a1, alu_b1, alu_op1, alu_invert1, alu_carry_in1);
  always_comb {alu_flags0, alu_result0} = alu_model(alu_a0, alu_b0, alu_op0, alu_invert0, alu_carry_in0);

  alu_wide_seq #(.CHAIN_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_invert(req_invert),
    .req_carry_in(req_carry_in), .req_wide(req_wide), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_flags(rsp_flags1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_invert(alu_invert1),
    .alu_carry_in(alu_carry_in1), .alu_n_oe(alu_n_oe1), .alu_result(alu_result1),
    .alu_flags(alu_flags1)
  );

  alu_wide_seq #(.CHAIN_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_invert(req_invert),
    .req_carry_in(req_carry_in), .req_wide(req_wide), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result0), .rsp_flags(rsp_flags0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_invert(alu_invert0),
    .alu_carry_in(alu_carry_in0), .alu_n_oe(alu_n_oe0), .alu_result(alu_result0),
    .alu_flags(alu_flags0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete op: accept, walk the passes, check the response, release it
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic inv, input logic cin,
                        input logic wide, input logic [15:0] exp_res,
                        input logic [3:0] exp_f1, input logic [3:0] exp_f0);
    logic [11:0] lo;
    lo = alu_model(a[7:0], b[7:0], op, inv, cin);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    req_invert = inv; req_carry_in = cin; req_wide = wide; rsp_ready = 1'b0;
    #1;
    check({tag, ":idle_ready"}, 16'(req_ready1), 16'd1);
    check({tag, ":idle_noe"},   16'(alu_n_oe1),  16'd1);
    step();
    req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 4'hF;
    req_invert = ~inv; req_carry_in = ~cin; req_wide = ~wide;
    check({tag, ":lo_noe"},   16'(alu_n_oe1),     16'd0);
    check({tag, ":lo_a"},     16'(alu_a1),        16'(a[7:0]));
    check({tag, ":lo_b"},     16'(alu_b1),        16'(b[7:0]));
    check({tag, ":lo_op"},    16'(alu_op1),       16'(op));
    check({tag, ":lo_inv"},   16'(alu_invert1),   16'(inv));
    check({tag, ":lo_cin"},   16'(alu_carry_in1), 16'(cin));
    check({tag, ":lo_valid"}, 16'(rsp_valid1),    16'd0);
    check({tag, ":lo_ready"}, 16'(req_ready1),    16'd0);
    if (wide) begin
      step();
      check({tag, ":hi_noe"},   16'(alu_n_oe1),     16'd0);
      check({tag, ":hi_a"},     16'(alu_a1),        16'(a[15:8]));
      check({tag, ":hi_b"},     16'(alu_b1),        16'(b[15:8]));
      check({tag, ":hi_cin"},   16'(alu_carry_in1), 16'(lo[9]));
      check({tag, ":hi_valid"}, 16'(rsp_valid1),    16'd0);
    end
    step();
    check({tag, ":valid1"},  16'(rsp_valid1), 16'd1);
    check({tag, ":valid0"},  16'(rsp_valid0), 16'd1);
    check({tag, ":result1"}, rsp_result1,     exp_res);
    check({tag, ":result0"}, rsp_result0,     exp_res);
    check({tag, ":flags1"},  16'(rsp_flags1), 16'(exp_f1));
    check({tag, ":flags0"},  16'(rsp_flags0), 16'(exp_f0));
    check({tag, ":done_noe"},   16'(alu_n_oe1),  16'd1);
    check({tag, ":done_ready"}, 16'(req_ready1), 16'd0);
    rsp_ready = 1'b1;
    #1;
    check({tag, ":done_take_ready"}, 16'(req_ready1), 16'd1);
    step();
    rsp_ready = 1'b0;
    check({tag, ":after_valid"}, 16'(rsp_valid1), 16'd0);
    check({tag, ":after_ready"}, 16'(req_ready1), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = 16'h0; req_b = 16'h0; req_op = 4'h0;
    req_invert = 1'b0; req_carry_in = 1'b0; req_wide = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    check("rst_valid",  16'(rsp_valid1), 16'd0);
    check("rst_result", rsp_result1,     16'h0000);
    check("rst_flags",  16'(rsp_flags1), 16'd0);
    check("rst_noe",    16'(alu_n_oe1),  16'd1);
    check("rst_ready",  16'(req_ready1), 16'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 16'(req_ready1), 16'd1);

    run_op("add_carry_chain", 16'h12FF, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b1, 16'h1300, 4'b0000, 4'b0000);
    run_op("add_wrap",        16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0011, 4'b0011);
    run_op("add_hi_wrap",     16'h0100, 16'hFF00, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0011, 4'b0011);
    run_op("zero_chain_diff", 16'h0101, 16'hFF00, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0001, 4'b0010, 4'b0011);
    run_op("byte_overflow",   16'hAB7F, 16'hCD01, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0080, 4'b1100, 4'b1100);
    run_op("xor_invert",      16'h5A3C, 16'h0F0F, 4'd3, 1'b1, 1'b0, 1'b1, 16'hAACC, 4'b0100, 4'b0100);
    run_op("sub_borrow",      16'h1000, 16'h0001, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0FFF, 4'b0010, 4'b0010);

    // Response held back five cycles, then released with a same-cycle accept
    req_valid = 1'b1; req_a = 16'h0001; req_b = 16'h0001; req_op = 4'd0;
    req_invert = 1'b0; req_carry_in = 1'b0; req_wide = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  16'(rsp_valid1),  16'd1);
      check("bp_result", rsp_result1,      16'h0002);
      check("bp_flags",  16'(rsp_flags1),  16'd0);
      check("bp_ready",  16'(req_ready1),  16'd0);
      check("bp_noe",    16'(alu_n_oe1),   16'd1);
      step();
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_a = 16'h0010; req_b = 16'h0020; req_wide = 1'b0;
    #1;
    check("b2b_ready", 16'(req_ready1), 16'd1);
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("b2b_lo_noe",   16'(alu_n_oe1),  16'd0);
    check("b2b_lo_valid", 16'(rsp_valid1), 16'd0);
    check("b2b_lo_a",     16'(alu_a1),     16'h0010);
    step();
    check("b2b_valid",  16'(rsp_valid1), 16'd1);
    check("b2b_result", rsp_result1,     16'h0030);
    check("b2b_flags",  16'(rsp_flags1), 16'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while the high pass is on the ALU
    req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h1111; req_wide = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("mid_hi_noe", 16'(alu_n_oe1), 16'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_noe",    16'(alu_n_oe1),   16'd1);
    check("mid_rst_valid",  16'(rsp_valid1),  16'd0);
    check("mid_rst_ready",  16'(req_ready1),  16'd0);
    check("mid_rst_result", rsp_result1,      16'h0000);
    step();
    step();
    check("mid_rst_hold_valid", 16'(rsp_valid1), 16'd0);
    rst_n = 1'b1;
    run_op("post_reset", 16'h00FF, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0011, 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wide_seq.md
ALU_WIDE_SEQ -- requirements
Module: alu_wide_seq

Interface
REQ-001 Parameter: CHAIN_ZERO, 1, zero flag of a 16-bit op is AND of both byte passes (0: high pass only).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer accepts request this cycle.
REQ-006 req_a, req_b  input  16 each  operands.
REQ-007 req_op  input  4  ALU op code (generated op table), passed unchanged to both passes.
REQ-008 req_invert, req_carry_in  input  1 each  ALU invert control; initial carry.
REQ-009 req_wide  input  1  1 = 16-bit (two passes), 0 = 8-bit (low byte only).
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes result.
REQ-012 rsp_result  output  16  result; high byte 0x00 in 8-bit mode.
REQ-013 rsp_flags  output  4  bit0 zero, bit1 carry, bit2 sign, bit3 overflow.
REQ-014 alu_a, alu_b  output  8 each  ALU operand bytes.
REQ-015 alu_op  output  4; alu_invert, alu_carry_in, alu_n_oe  output  1 each  ALU controls.
REQ-016 alu_result  input  8; alu_flags  input  4  combinational ALU outputs, same flag order.

Function
REQ-017 FSM states IDLE, LO, HI, DONE; request fields latched into internal registers on acceptance.
REQ-018 req_ready SHALL be 1 in IDLE, and in DONE when rsp_ready=1; 0 otherwise.
REQ-019 Acceptance (req_valid & req_ready) SHALL move to LO; otherwise IDLE stays IDLE.
REQ-020 LO: alu_a/alu_b = latched low bytes, alu_carry_in = latched carry, alu_n_oe=0; at clock edge store alu_result as low byte, alu_flags into flag scratch; next HI if wide else DONE.
REQ-021 HI: alu_a/alu_b = high bytes, alu_carry_in = carry flag stored in LO, alu_n_oe=0; store high byte; next DONE.
REQ-022 alu_op and alu_invert SHALL equal latched values in LO and HI; in IDLE/DONE all alu_* outputs 0 except alu_n_oe=1.
REQ-023 Wide flags: carry, sign, overflow from HI pass; zero = zero_LO & zero_HI (CHAIN_ZERO=1) or zero_HI (0).
REQ-024 Byte flags: all four from LO pass; rsp_result[15:8]=0.
REQ-025 DONE: rsp_valid=1, rsp_result/rsp_flags stable until rsp_ready=1.
REQ-026 DONE with rsp_ready=1: next LO if simultaneous acceptance, else IDLE; back-to-back throughput = one op per 3 cycles (wide) or 2 (byte).
REQ-027 Latency: acceptance at edge N -> rsp_valid high after edge N+3 (wide) or N+2 (byte).
REQ-028 rsp_valid=0 outside DONE; request inputs ignored outside acceptance cycles.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_result=0, rsp_flags=0, all latched fields 0, alu_n_oe=1, req_ready=0 while low.
REQ-030 Reset mid-operation SHALL discard the in-flight op; no response produced; first accept possible on first edge after release.

Structure
REQ-031 Shared package: state encoding, flag bit indices (ZERO=0, CARRY=1, SIGN=2, OVERFLOW=3).
REQ-032 No sub-module; single FSM plus datapath registers; the ALU is instantiated by the parent/bench, not inside.

Verification (bench wires a real ALU instance to alu_* ports)
REQ-033 Wide add 0x12FF+0x0001, carry_in 0 -> LO carry 1 fed to HI; result 0x1300, flags Z0 C0 S0 V0, rsp_valid 3 cycles after accept.
REQ-034 Wide add 0xFFFF+0x0001 -> result 0x0000, Z1 C1; with CHAIN_ZERO=0 and 0x0100+0xFF00 -> 0x0000, Z1 (both params exercised).
REQ-035 Byte add 0x7F+0x01 (wide=0) -> result 0x0080, S1 V1 Z0, rsp_valid 2 cycles after accept.
REQ-036 rsp_ready held 0 for 5 cycles in DONE -> outputs stable, req_ready 0; then rsp_ready=1 with req_valid=1 -> same-cycle accept, next op enters LO.
REQ-037 Assert rst_n=0 during HI -> rsp_valid stays 0, alu_n_oe=1 immediately; next request after release completes normally.
REQ-038 Check alu_n_oe=0 only in LO/HI for every scenario.
